lm_sm_sequencer: RTL and testbench

Multi-cycle micro-sequencer for Load-Multiple (LM, opcode 0110) and Store-Multiple (SM, opcode 0111) in the 16-bit RISC pipeline. Sits at the ID/RR boundary. It detects LM/SM in the RR stage, freezes the front end, and replaces the instruction with one single-register memory micro-op per set mask bit into RR/EX. It supplies the register index, memory address and last-op flag that drive the RF A3/D3 selection and LM/SM muxes in the control unit.

---
 rtl/lm_sm_sequencer.sv | 118 +++++++++++
 tb/tb_lm_sm_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/lm_sm_sequencer.sv
// Load/Store-Multiple micro-sequencer: expands an LM/SM in RR into one
// single-register memory micro-op per set mask bit, ascending register order.
module lm_sm_sequencer #(
  parameter logic [15:0] ADDR_STEP = 16'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ID_RR_IR,
  input  logic        ID_RR_VALID,
  input  logic [15:0] BASE_ADDR,
  input  logic        HOLD,
  input  logic        FLUSH,
  output logic        STALL,
  output logic        BUBBLE,
  output logic        UOP_VALID,
  output logic        UOP_IS_LOAD,
  output logic [2:0]  UOP_REG,
  output logic [15:0] UOP_ADDR,
  output logic        UOP_LAST,
  output logic        BUSY,
  output logic        IS_IMM_ZERO_SM
);

  // Handshake: a micro-op is offered while UOP_VALID=1 and is consumed on
  // every rising edge where HOLD=0; with HOLD=1 the same micro-op is re-offered.

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  state_t      state, state_n;
  logic [7:0]  rem_mask, rem_mask_n;
  logic [15:0] addr, addr_n;
  logic        is_load, is_load_n;

  logic [3:0]  opcode;
  logic [7:0]  ir_mask;
  logic        is_lmsm;
  logic        start;
  logic [2:0]  cur_idx;
  logic [7:0]  cur_bit;
  logic        single;

  assign opcode  = ID_RR_IR[15:12];
  assign ir_mask = ID_RR_IR[7:0];
  assign is_lmsm = ID_RR_VALID && ((opcode == OP_LM) || (opcode == OP_SM));
  assign start   = (state == IDLE) && is_lmsm && (ir_mask != 8'd0) && !FLUSH && !HOLD;

  // Mask bit (7-i) selects Ri, so the lowest pending register is the highest set bit.
  always_comb begin
    cur_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rem_mask[7-i]) cur_idx = 3'(i);
    end
  end

  assign cur_bit = 8'd1 << (3'd7 - cur_idx);
  assign single  = (rem_mask != 8'd0) && ((rem_mask & (rem_mask - 8'd1)) == 8'd0);

  always_comb begin
    state_n    = state;
    rem_mask_n = rem_mask;
    addr_n     = addr;
    is_load_n  = is_load;
    if (FLUSH) begin
      state_n    = IDLE;
      rem_mask_n = 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_n    = RUN;
            rem_mask_n = ir_mask;
            addr_n     = BASE_ADDR;
            is_load_n  = (opcode == OP_LM);
          end
        end
        RUN: begin
          if (!HOLD) begin
            rem_mask_n = rem_mask & ~cur_bit;
            addr_n     = addr + ADDR_STEP;
            if (single) state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rem_mask <= 8'd0;
      addr     <= 16'd0;
      is_load  <= 1'b0;
    end else begin
      state    <= state_n;
      rem_mask <= rem_mask_n;
      addr     <= addr_n;
      is_load  <= is_load_n;
    end
  end

  // The front end is released during the final accepted micro-op so that
  // ID/RR advances in lockstep with the sequence end.
  assign STALL  = start || ((state == RUN) && !FLUSH && !(single && !HOLD));
  assign BUBBLE = start;
  assign IS_IMM_ZERO_SM = is_lmsm && (ir_mask == 8'd0);

  assign BUSY        = (state == RUN);
  assign UOP_VALID   = (state == RUN);
  assign UOP_IS_LOAD = is_load;
  assign UOP_REG     = cur_idx;
  assign UOP_ADDR    = addr;
  assign UOP_LAST    = (state == RUN) && single;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed bench for lm_sm_sequencer: front-end signals checked per cycle,
// micro-ops checked by a monitor against an expected queue.
module tb_lm_sm_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ID_RR_IR;
  logic        ID_RR_VALID;
  logic [15:0] BASE_ADDR;
  logic        HOLD;
  logic        FLUSH;
  logic        STALL, BUBBLE, UOP_VALID, UOP_IS_LOAD, UOP_LAST, BUSY, IS_IMM_ZERO_SM;
  logic [2:0]  UOP_REG;
  logic [15:0] UOP_ADDR;

  int checks = 0;
  int errors = 0;

  // {is_load, reg, addr, last}
  logic [20:0] exp_q[$];

  lm_sm_sequencer dut (
    .clk(clk), .rst(rst), .ID_RR_IR(ID_RR_IR), .ID_RR_VALID(ID_RR_VALID),
    .BASE_ADDR(BASE_ADDR), .HOLD(HOLD), .FLUSH(FLUSH), .STALL(STALL),
    .BUBBLE(BUBBLE), .UOP_VALID(UOP_VALID), .UOP_IS_LOAD(UOP_IS_LOAD),
    .UOP_REG(UOP_REG), .UOP_ADDR(UOP_ADDR), .UOP_LAST(UOP_LAST), .BUSY(BUSY),
    .IS_IMM_ZERO_SM(IS_IMM_ZERO_SM)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic set_ir(input logic [3:0] op, input logic [7:0] mask, input logic [15:0] base);
    ID_RR_IR    = {op, 3'd2, 1'b0, mask};
    ID_RR_VALID = 1'b1;
    BASE_ADDR   = base;
  endtask

  task automatic clr_ir();
    ID_RR_IR    = 16'h0000;
    ID_RR_VALID = 1'b0;
    BASE_ADDR   = 16'h0000;
  endtask

  task automatic push_uop(input logic ld, input logic [2:0] r, input logic [15:0] a, input logic last);
    exp_q.push_back({ld, r, a, last});
  endtask

  task automatic step(input logic e_stall, input logic e_bubble, input logic e_busy, input logic e_zero);
    @(negedge clk);
    chk("stall", 32'(STALL), 32'(e_stall));
    chk("bubble", 32'(BUBBLE), 32'(e_bubble));
    chk("busy", 32'(BUSY), 32'(e_busy));
    chk("imm_zero", 32'(IS_IMM_ZERO_SM), 32'(e_zero));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_valid", 32'(UOP_VALID), 32'd0);
    chk("rst_is_load", 32'(UOP_IS_LOAD), 32'd0);
    chk("rst_reg", 32'(UOP_REG), 32'd0);
    chk("rst_addr", 32'(UOP_ADDR), 32'd0);
    chk("rst_last", 32'(UOP_LAST), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
  endtask

  // scoreboard monitor: every cycle a micro-op is offered, it must match the queue head
  always @(negedge clk) begin
    if (UOP_VALID === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL uop_unexpected: got reg %0d addr 0x%0h, expected none at %0t",
                 UOP_REG, UOP_ADDR, $time);
      end else begin
        logic [20:0] e;
        e = exp_q.pop_front();
        if ({UOP_IS_LOAD, UOP_REG, UOP_ADDR, UOP_LAST} !== e) begin
          errors++;
          $display("FAIL uop: got ld=%0d reg=%0d addr=0x%0h last=%0d expected ld=%0d reg=%0d addr=0x%0h last=%0d at %0t",
                   UOP_IS_LOAD, UOP_REG, UOP_ADDR, UOP_LAST,
                   e[20], e[19:17], e[16:1], e[0], $time);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; HOLD = 1'b0; FLUSH = 1'b0;
    clr_ir();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_reset_outputs();
    chk("rst_stall", 32'(STALL), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // SM mask 0x81, base 0x0040: R0 then R7
    push_uop(1'b0, 3'd0, 16'h0040, 1'b0);
    push_uop(1'b0, 3'd7, 16'h0041, 1'b1);
    set_ir(4'b0111, 8'h81, 16'h0040);
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    clr_ir();
    step(0, 0, 0, 0);

    // LM mask 0xFF, base 0xFFFE with address wrap
    for (int i = 0; i < 8; i++)
      push_uop(1'b1, 3'(i), 16'hFFFE + 16'(i), i == 7);
    set_ir(4'b0110, 8'hFF, 16'hFFFE);
    step(1, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    clr_ir();
    step(0, 0, 0, 0);

    // LM mask 0x00: flows as NOP
    set_ir(4'b0110, 8'h00, 16'h1234);
    step(0, 0, 0, 1);
    clr_ir();
    step(0, 0, 0, 0);

    // non-LM/SM opcode and HOLD in IDLE: no start
    set_ir(4'b0000, 8'hFF, 16'h1111);
    step(0, 0, 0, 0);
    set_ir(4'b0110, 8'h80, 16'h2222);
    HOLD = 1'b1;
    step(0, 0, 0, 0);
    HOLD = 1'b0;
    clr_ir();
    step(0, 0, 0, 0);

    // SM mask 0x15 with 3 HOLD cycles on R5
    push_uop(1'b0, 3'd3, 16'h0100, 1'b0);
    repeat (4) push_uop(1'b0, 3'd5, 16'h0101, 1'b0);
    push_uop(1'b0, 3'd7, 16'h0102, 1'b1);
    set_ir(4'b0111, 8'h15, 16'h0100);
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    HOLD = 1'b1;
    repeat (3) step(1, 0, 1, 0);
    HOLD = 1'b0;
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    clr_ir();
    step(0, 0, 0, 0);

    // FLUSH on 2nd of 4 micro-ops, then a fresh LM starts immediately
    push_uop(1'b1, 3'd4, 16'h0200, 1'b0);
    push_uop(1'b1, 3'd5, 16'h0201, 1'b0);
    set_ir(4'b0110, 8'h0F, 16'h0200);
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    FLUSH = 1'b1;
    step(0, 0, 1, 0);
    FLUSH = 1'b0;
    push_uop(1'b1, 3'd1, 16'h0300, 1'b1);
    set_ir(4'b0110, 8'h40, 16'h0300);
    step(1, 1, 0, 0);
    step(0, 0, 1, 0);
    clr_ir();
    step(0, 0, 0, 0);

    // rst mid-RUN, then the same LM is re-sequenced from R0
    push_uop(1'b1, 3'd0, 16'h0400, 1'b0);
    push_uop(1'b1, 3'd1, 16'h0401, 1'b0);
    set_ir(4'b0110, 8'hF0, 16'h0400);
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    rst = 1'b1;
    step(1, 0, 1, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++)
      push_uop(1'b1, 3'(i), 16'h0400 + 16'(i), i == 3);
    @(negedge clk);
    chk_reset_outputs();
    chk("restart_stall", 32'(STALL), 32'd1);
    chk("restart_bubble", 32'(BUBBLE), 32'd1);
    @(posedge clk); #1;
    repeat (3) step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    clr_ir();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
